// File: rtl/sysarr_host_ctrl.sv
// Host-side byte-stream driver/collector for the 3x3 systolic array.
// Optional: define SYSARR_HOST_CSUM_EN to append an XOR checksum byte to each result.
module sysarr_host_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned TO_W           = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [71:0] arr_a,
  output logic [71:0] arr_b,
  output logic        arr_start,
  input  logic        arr_valid,
  input  logic [71:0] arr_c,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {S_LOAD, S_ARM, S_WAIT, S_DRAIN} state_t;

`ifdef SYSARR_HOST_CSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [71:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            arr_start_q, arr_start_d;
  logic            err_q, err_d;
  logic            in_ready_q, in_ready_d;
  logic            accept;

  function automatic logic [7:0] res_byte(input logic [71:0] r, input logic [3:0] idx);
    logic [7:0] b;
    b = '0;
    for (int unsigned k = 0; k < 9; k++)
      if (idx == 4'(k)) b = r[8*k +: 8];
`ifdef SYSARR_HOST_CSUM_EN
    if (idx == 4'd9) begin
      b = '0;
      for (int unsigned k = 0; k < 9; k++) b = b ^ r[8*k +: 8];
    end
`endif
    return b;
  endfunction

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    to_d        = to_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    arr_start_d = arr_start_q;
    err_d       = err_q;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          for (int unsigned k = 0; k < 9; k++) begin
            if (cnt_q == 5'(k))     a_d[8*k +: 8] = in_data;
            if (cnt_q == 5'(k + 9)) b_d[8*k +: 8] = in_data;
          end
          if (cnt_q == 5'd0) err_d = 1'b0;
          if (cnt_q == 5'd17) begin
            cnt_d   = '0;
            state_d = S_ARM;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_ARM: begin
        // Hold off until the array has released the previous result.
        if (!arr_valid) begin
          arr_start_d = 1'b1;
          to_d        = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result arriving on the expiry cycle still counts as success.
        if (arr_valid) begin
          res_d       = arr_c;
          arr_start_d = 1'b0;
          idx_d       = '0;
          state_d     = S_DRAIN;
        end else begin
          to_d = to_q + TO_W'(1);
          if (to_d == TO_W'(TIMEOUT_CYCLES)) begin
            err_d       = 1'b1;
            arr_start_d = 1'b0;
            cnt_d       = '0;
            state_d     = S_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = res_byte(res_q, idx_q);
        end else if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = S_LOAD;
          end else begin
            idx_d      = idx_q + 4'd1;
            out_data_d = res_byte(res_q, idx_q + 4'd1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    in_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      to_q        <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      arr_start_q <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      to_q        <= to_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      arr_start_q <= arr_start_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign arr_a     = a_q;
  assign arr_b     = b_q;
  assign arr_start = arr_start_q;
  assign err       = err_q;
  assign busy      = !((state_q == S_LOAD) && (cnt_q == 5'd0));

endmodule

// File: tb/tb_sysarr_host_ctrl.sv
// Directed bench for sysarr_host_ctrl with a behavioural XOR array stub.
module tb_sysarr_host_ctrl;

`ifdef SYSARR_HOST_CSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] arr_a, arr_b, arr_c;
  logic        arr_start;
  logic        arr_valid;
  logic        busy, err;

  logic        stub_v, stub_en, stub_force;
  int          stub_cnt;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [7:0]  ops[18];
  logic [7:0]  exp_b[10];

  always #5 clk = ~clk;

  sysarr_host_ctrl #(.TIMEOUT_CYCLES(32), .TO_W(6)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .arr_a(arr_a), .arr_b(arr_b), .arr_start(arr_start),
    .arr_valid(arr_valid), .arr_c(arr_c),
    .busy(busy), .err(err)
  );

  // Array stub: valid 8 cycles after start rises, drops one cycle after start falls.
  assign arr_c     = arr_a ^ arr_b;
  assign arr_valid = stub_v | stub_force;

  always @(posedge clk) begin
    if (!arr_start) begin
      stub_cnt <= 0;
      stub_v   <= 1'b0;
    end else if (stub_en && !stub_v) begin
      if (stub_cnt == 7) stub_v <= 1'b1;
      else stub_cnt <= stub_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [71:0] pack(input int base);
    logic [71:0] p;
    p = '0;
    for (int k = 0; k < 9; k++) p[8*k +: 8] = ops[base + k];
    return p;
  endfunction

  task automatic set_exp_from_ops();
    logic [7:0] cs;
    cs = '0;
    for (int k = 0; k < 9; k++) begin
      exp_b[k] = ops[k] ^ ops[k + 9];
      cs = cs ^ exp_b[k];
    end
    exp_b[9] = cs;
  endtask

  task automatic send(input int lo, input int hi, input bit gaps);
    int t;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = ops[i];
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("in_ready_wait", {71'd0, in_ready}, 72'd1);
      @(posedge clk);
      if (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (!arr_start && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("start_seen", {71'd0, arr_start}, 72'd1);
  endtask

  task automatic collect(input int stall);
    int t;
    for (int i = 0; i < NB; i++) begin
      t = 0;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("out_valid_seen", {71'd0, out_valid}, 72'd1);
      if (i == 0 && stall > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          chk("bp_hold_data", {64'd0, out_data}, {64'd0, exp_b[0]});
          chk("bp_hold_valid", {71'd0, out_valid}, 72'd1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("out_byte%0d", i), {64'd0, out_data}, {64'd0, exp_b[i]});
      @(negedge clk);
    end
    chk("drain_end_valid", {71'd0, out_valid}, 72'd0);
    chk("drain_end_busy", {71'd0, busy}, 72'd0);
    chk("drain_end_ready", {71'd0, in_ready}, 72'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    bit saw_ov;
    logic [71:0] basic_c;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    stub_en = 1'b1; stub_force = 1'b0;
    #1;
    chk("rst_in_ready", {71'd0, in_ready}, 72'd0);
    chk("rst_busy", {71'd0, busy}, 72'd0);
    chk("rst_err", {71'd0, err}, 72'd0);
    chk("rst_out_valid", {71'd0, out_valid}, 72'd0);
    chk("rst_out_data", {64'd0, out_data}, 72'd0);
    chk("rst_arr_start", {71'd0, arr_start}, 72'd0);
    chk("rst_arr_a", arr_a, 72'd0);
    chk("rst_arr_b", arr_b, 72'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {71'd0, in_ready}, 72'd1);

    // Basic run
    for (int i = 0; i < 9; i++) ops[i] = 8'(i + 1);
    for (int i = 0; i < 9; i++) ops[i + 9] = 8'(8'h10 + i);
    basic_c = 72'h11_1F_11_13_11_17_11_13_11;
    for (int k = 0; k < 9; k++) exp_b[k] = basic_c[8*k +: 8];
    exp_b[9] = 8'h19;
    send(0, 17, 1'b0);
    wait_start();
    chk("basic_arr_a", arr_a, 72'h090807060504030201);
    chk("basic_arr_b", arr_b, 72'h181716151413121110);
    chk("basic_busy", {71'd0, busy}, 72'd1);
    chk("basic_in_ready", {71'd0, in_ready}, 72'd0);
    hi = 0;
    while (!arr_valid && hi < 50) begin
      @(negedge clk);
      hi++;
    end
    chk("basic_arr_valid", {71'd0, arr_valid}, 72'd1);
    @(negedge clk);
    chk("lat_capture_no_valid", {71'd0, out_valid}, 72'd0);
    chk("lat_start_dropped", {71'd0, arr_start}, 72'd0);
    @(negedge clk);
    chk("lat_out_valid", {71'd0, out_valid}, 72'd1);
    collect(0);
    chk("basic_err", {71'd0, err}, 72'd0);

    // Back-to-back with array still reporting valid: ARM must hold off start
    stub_force = 1'b1;
    for (int i = 0; i < 18; i++) ops[i] = 8'(i * 17 + 3);
    set_exp_from_ops();
    send(0, 17, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("arm_hold_start", {71'd0, arr_start}, 72'd0);
      chk("arm_busy", {71'd0, busy}, 72'd1);
      @(negedge clk);
    end
    stub_force = 1'b0;
    wait_start();
    chk("b2b_arr_a", arr_a, pack(0));
    chk("b2b_arr_b", arr_b, pack(9));
    collect(0);

    // Output backpressure
    for (int i = 0; i < 9; i++) ops[i] = 8'(i + 1);
    for (int i = 0; i < 9; i++) ops[i + 9] = 8'(8'h10 + i);
    for (int k = 0; k < 9; k++) exp_b[k] = basic_c[8*k +: 8];
    exp_b[9] = 8'h19;
    send(0, 17, 1'b0);
    collect(5);

    // Timeout
    stub_en = 1'b0;
    send(0, 17, 1'b0);
    wait_start();
    hi = 0; saw_ov = 1'b0;
    while (arr_start && hi < 100) begin
      @(negedge clk);
      hi++;
      if (out_valid) saw_ov = 1'b1;
    end
    chk("to_start_cycles", 72'(hi), 72'd32);
    chk("to_err", {71'd0, err}, 72'd1);
    chk("to_no_out", {71'd0, saw_ov}, 72'd0);
    chk("to_busy", {71'd0, busy}, 72'd0);
    chk("to_in_ready", {71'd0, in_ready}, 72'd1);
    stub_en = 1'b1;
    send(0, 0, 1'b0);
    chk("to_err_cleared", {71'd0, err}, 72'd0);
    chk("to_busy_after_byte", {71'd0, busy}, 72'd1);
    send(1, 17, 1'b0);
    collect(0);

    // Reset mid-WAIT, then a gapped fresh load
    send(0, 17, 1'b0);
    wait_start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_arr_start", {71'd0, arr_start}, 72'd0);
    chk("midrst_busy", {71'd0, busy}, 72'd0);
    chk("midrst_in_ready", {71'd0, in_ready}, 72'd0);
    chk("midrst_arr_a", arr_a, 72'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", {71'd0, in_ready}, 72'd1);
    chk("midrst_out_valid", {71'd0, out_valid}, 72'd0);
    for (int i = 0; i < 9; i++) ops[i] = 8'(8'hA0 + 3 * i);
    for (int i = 0; i < 9; i++) ops[i + 9] = 8'(8'h5C - 5 * i);
    set_exp_from_ops();
    send(0, 17, 1'b1);
    wait_start();
    chk("gap_arr_a", arr_a, pack(0));
    chk("gap_arr_b", arr_b, pack(9));
    collect(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
